// File: rtl/scan_select_sequencer.sv
// Channel-select sequencer feeding a 2:4 one-hot decoder: blank, dwell, step through ch_mask.
// Optional SCAN_SWEEP_CNT_EN adds an 8-bit completed-sweep counter output (sweep_cnt).
module scan_select_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_valid,
  output logic               busy,
  output logic               done
`ifdef SCAN_SWEEP_CNT_EN
  ,
  output logic [7:0]         sweep_cnt
`endif
);

  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic ZERO_BLANK = (BLANK_CYC == 0);

  typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;
  localparam state_t ENTRY_STATE = ZERO_BLANK ? DWELL : BLANK;

  state_t             state;
  logic [1:0]         sel;
  logic [3:0]         mask_reg;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [BW-1:0]      blank_cnt;

  logic [DWELL_W-1:0] dwell_eff;
  logic               low_any;
  logic [1:0]         low_ch;
  logic               nxt_any;
  logic [1:0]         nxt_ch;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // low_*: lowest enabled channel of the live mask (used at start and wrap);
  // nxt_*: next enabled channel above the current one in the latched mask.
  always_comb begin
    low_any = 1'b0;
    low_ch  = 2'd0;
    nxt_any = 1'b0;
    nxt_ch  = sel;
    for (int k = 3; k >= 0; k--) begin
      if (ch_mask[k]) begin
        low_any = 1'b1;
        low_ch  = 2'(k);
      end
      if (mask_reg[k] && (2'(k) > sel)) begin
        nxt_any = 1'b1;
        nxt_ch  = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      mask_reg  <= 4'd0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SCAN_SWEEP_CNT_EN
      sweep_cnt <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        sel_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (low_any) begin
                mask_reg  <= ch_mask;
                sel       <= low_ch;
                busy      <= 1'b1;
                state     <= ENTRY_STATE;
                sel_valid <= ZERO_BLANK;
                blank_cnt <= BW'(BLANK_CYC);
                dwell_cnt <= dwell_eff;
              end else begin
                done <= 1'b1;
              end
            end
          end

          BLANK: begin
            if (blank_cnt <= BW'(1)) begin
              state     <= DWELL;
              sel_valid <= 1'b1;
              dwell_cnt <= dwell_eff;
            end else begin
              blank_cnt <= blank_cnt - BW'(1);
            end
          end

          DWELL: begin
            if (dwell_cnt > DWELL_W'(1)) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else if (nxt_any) begin
              sel       <= nxt_ch;
              state     <= ENTRY_STATE;
              sel_valid <= ZERO_BLANK;
              blank_cnt <= BW'(BLANK_CYC);
              dwell_cnt <= dwell_eff;
            end else begin
              // Last enabled channel finished: the sweep is complete either way.
`ifdef SCAN_SWEEP_CNT_EN
              sweep_cnt <= sweep_cnt + 8'd1;
`endif
              if (continuous && low_any) begin
                mask_reg  <= ch_mask;
                sel       <= low_ch;
                state     <= ENTRY_STATE;
                sel_valid <= ZERO_BLANK;
                blank_cnt <= BW'(BLANK_CYC);
                dwell_cnt <= dwell_eff;
              end else begin
                state     <= IDLE;
                sel_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end

          default: begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel_a = sel[1];
  assign sel_b = sel[0];

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Self-checking bench for scan_select_sequencer: vector table, directed corner cases,
// and randomized scans compared against a per-cycle trace model.
module tb_scan_select_sequencer;

  localparam int DWELL_W   = 8;
  localparam int BLANK_CYC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         continuous;
  logic [3:0]   ch_mask;
  logic [7:0]   dwell;
  logic         sel_a;
  logic         sel_b;
  logic         sel_valid;
  logic         busy;
  logic         done;
`ifdef SCAN_SWEEP_CNT_EN
  logic [7:0]   sweep_cnt;
`endif

  int tests = 0;
  int fails = 0;

  scan_select_sequencer #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .done       (done)
`ifdef SCAN_SWEEP_CNT_EN
    ,
    .sweep_cnt  (sweep_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       valid;
    logic       bsy;
    logic       dn;
    int         sw;
  } exp_t;

  typedef struct {
    logic       st;
    logic       sp;
    logic       cont;
    logic [3:0] mask;
    logic [7:0] dw;
    logic [1:0] e_sel;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  exp_t       exp_q[$];
  logic [1:0] exp_last_sel = 2'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int cyc, input logic [1:0] s,
                           input logic v, input logic b, input logic d);
    tests++;
    if ({sel_a, sel_b, sel_valid, busy, done} !== {s, v, b, d}) begin
      fails++;
      $display("FAIL %s cyc %0d: got sel=%b%b valid=%b busy=%b done=%b, expected sel=%b valid=%b busy=%b done=%b",
               name, cyc, sel_a, sel_b, sel_valid, busy, done, s, v, b, d);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  function automatic void push_exp(logic [1:0] s, logic v, logic b, logic d, int sw);
    exp_t e;
    e.sel = s; e.valid = v; e.bsy = b; e.dn = d; e.sw = sw;
    exp_q.push_back(e);
  endfunction

  function automatic logic [3:0] mask_of(int k, logic [3:0] m0, logic [3:0] m1, int n0);
    return (k < n0) ? m0 : m1;
  endfunction

  // Expected trace: each enabled channel, ascending, gets BLANK_CYC blank cycles then
  // max(dwell,1) valid cycles; sweeps chain back-to-back; finally a single done cycle.
  task automatic run_scan(input string name, input logic [3:0] m0, input logic [3:0] m1,
                          input int n0, input int total, input int d, input bit noise,
                          output int first_done, output int done_cnt);
    int         dmax;
    int         n;
    int         s;
    logic [3:0] m;
    logic [1:0] last;
    dmax = (d == 0) ? 1 : d;
    last = exp_last_sel;
    exp_q.delete();
    for (int sw = 0; sw < total; sw++) begin
      m = mask_of(sw, m0, m1, n0);
      if (m == 4'd0) break;
      for (int ch = 0; ch < 4; ch++) begin
        if (m[ch]) begin
          for (int j = 0; j < BLANK_CYC; j++) push_exp(2'(ch), 1'b0, 1'b1, 1'b0, sw);
          for (int j = 0; j < dmax; j++)      push_exp(2'(ch), 1'b1, 1'b1, 1'b0, sw);
          last = 2'(ch);
        end
      end
    end
    push_exp(last, 1'b0, 1'b0, 1'b1, total);
    exp_last_sel = last;
    n = exp_q.size();
    first_done = -1;
    done_cnt = 0;

    start = 1'b1; stop = 1'b0; ch_mask = m0; dwell = 8'(d);
    continuous = (total > 1);
    tick();
    for (int i = 0; i < n; i++) begin
      check_out(name, i, exp_q[i].sel, exp_q[i].valid, exp_q[i].bsy, exp_q[i].dn);
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
      end
      s = exp_q[i].sw;
      ch_mask = mask_of(s + 1, m0, m1, n0);
      continuous = (s < total - 1);
      start = (noise && i < n - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (noise && total == 1) ch_mask = 4'($urandom_range(0, 15));
      tick();
    end
    check_out({name, "_idle"}, n, last, 1'b0, 1'b0, 1'b0);
    start = 1'b0; continuous = 1'b0; ch_mask = 4'd0;
  endtask

  vec_t vecs[14];

  initial begin
    int fd;
    int dc;
    logic [3:0] r0;
    logic [3:0] r1;
    int tot;
    int n0;

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; ch_mask = 4'd0; dwell = 8'd0;
    repeat (3) tick();
    check_out("reset_held", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("reset_release", 0, 2'd0, 1'b0, 1'b0, 1'b0);

    // start/stop/mask-zero/busy-ignore sequence, one row per clock edge
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 8'd1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b0100, 8'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 8'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 8'd1, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 8'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'b1111, 8'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 8'd1, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].st; stop = vecs[i].sp; continuous = vecs[i].cont;
      ch_mask = vecs[i].mask; dwell = vecs[i].dw;
      tick();
      check_out("vec", i, vecs[i].e_sel, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_done);
    end
    start = 1'b0; stop = 1'b0;
    exp_last_sel = 2'd2;

    run_scan("sweep1111", 4'b1111, 4'b1111, 1, 1, 3, 1'b0, fd, dc);
    check_int("sweep1111_done_at", fd, 20);
    check_int("sweep1111_done_count", dc, 1);

    run_scan("cont1010_d0", 4'b1010, 4'b1010, 3, 3, 0, 1'b0, fd, dc);
    check_int("cont1010_done_count", dc, 1);

    run_scan("mask_change", 4'b1010, 4'b0100, 1, 2, 2, 1'b0, fd, dc);
    run_scan("wrap_to_zero", 4'b0011, 4'b0000, 1, 3, 1, 1'b0, fd, dc);
    check_int("wrap_to_zero_done_count", dc, 1);
    run_scan("mask_zero", 4'b0000, 4'b0000, 1, 1, 1, 1'b0, fd, dc);
    check_int("mask_zero_done_at", fd, 0);

    for (int r = 0; r < 30; r++) begin
      r0  = 4'($urandom_range(0, 15));
      r1  = 4'($urandom_range(0, 15));
      tot = $urandom_range(1, 3);
      n0  = $urandom_range(1, tot);
      run_scan($sformatf("rand%0d", r), r0, r1, n0, tot, $urandom_range(0, 4), 1'b1, fd, dc);
    end

    // asynchronous reset in the middle of a dwell window
    start = 1'b1; ch_mask = 4'b1111; dwell = 8'd3; continuous = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_out("pre_async_rst", 0, 2'd0, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    check_out("after_async_rst", 1, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_last_sel = 2'd0;

`ifdef SCAN_SWEEP_CNT_EN
    check_int("sweep_cnt_reset", int'(sweep_cnt), 0);
    run_scan("cnt256", 4'b0001, 4'b0001, 256, 256, 0, 1'b0, fd, dc);
    check_int("sweep_cnt_256", int'(sweep_cnt), 0);
    run_scan("cnt1", 4'b0010, 4'b0010, 1, 1, 1, 1'b0, fd, dc);
    check_int("sweep_cnt_1", int'(sweep_cnt), 1);
    start = 1'b1; ch_mask = 4'b0001; dwell = 8'd1;
    tick();
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check_int("sweep_cnt_abort", int'(sweep_cnt), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
